dmem_port_arbiter: RTL and testbench

Shares the single-port data SRAM (active-low chip select/write enable, 1-cycle read latency) between two requesters: port 0, the pipeline MEMORY stage, and port 1, the program/data loader used to preload and dump memory around START. It issues same-cycle grants, drives the SRAM pins from the granted port, and routes read data back one cycle later. Arbitration is fixed-priority with starvation protection, or round-robin, selected by parameter.

---
 rtl/dmem_port_arbiter_pkg.sv | 21 ++
 rtl/dmem_port_arbiter_starve_cnt.sv | 40 ++++
 rtl/dmem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_dmem_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter.
//   port_e    : requester identity (pipeline MEMORY stage or loader)
//   mem_req_t : one requester's access bundle at the default SRAM geometry
package dmem_port_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 9;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic {
        PORT_MEM = 1'b0,
        PORT_LDR = 1'b1
    } port_e;

    typedef struct packed {
        logic                  req;
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_port_arbiter_starve_cnt.sv
// Saturating wait counter for the loader port.
//   CLK, RSTn : clock, synchronous active-low reset
//   inc       : count one more starved cycle (saturates at MAX)
//   clr       : clear to zero, takes priority over inc
//   at_max    : counter has reached MAX
// With neither inc nor clr the count holds.
module dmem_port_arbiter_starve_cnt #(
    parameter int unsigned MAX = 8
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [7:0] MaxVal = 8'(MAX);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_max = (cnt_q == MaxVal);

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data SRAM.
//   CLK, RSTn            : clock, synchronous active-low reset
//   EN                   : global enable, 0 blocks new grants
//   p0_* (MEMORY stage)  : req/we/addr/wdata in, gnt/rvalid/rdata out
//   p1_* (loader)        : same as port 0
//   csb0/web0/addr0/din0 : SRAM pins (active-low select and write enable)
//   dout0                : SRAM read data, valid the cycle after a read access
// Grants are combinational; read data returns one cycle after the read grant.
// FIXED_PRIO=1 favours port 0 with a starvation guard for port 1,
// FIXED_PRIO=0 alternates between ports when both request.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned DATA_W     = 32,
    parameter bit          FIXED_PRIO = 1'b1,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              EN,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] dout0
);

    port_e last_gnt_q, last_gnt_d;
    logic  rd_pend_q, rd_pend_d;
    port_e rd_port_q, rd_port_d;
    logic  force_ldr;

    generate
        if (FIXED_PRIO) begin : g_starve
            logic at_max;

            dmem_port_arbiter_starve_cnt #(
                .MAX (STARVE_MAX)
            ) u_starve_cnt (
                .CLK    (CLK),
                .RSTn   (RSTn),
                .inc    (EN & p1_req & ~p1_gnt),
                .clr    (~p1_req | p1_gnt),
                .at_max (at_max)
            );

            assign force_ldr = at_max & p1_req;
        end else begin : g_no_starve
            assign force_ldr = 1'b0;
        end
    endgenerate

    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (EN) begin
            if (p0_req && p1_req) begin
                if (FIXED_PRIO) begin
                    p1_gnt = force_ldr;
                    p0_gnt = ~force_ldr;
                end else begin
                    // Round-robin: the port that did not win last time goes now.
                    p1_gnt = (last_gnt_q == PORT_MEM);
                    p0_gnt = (last_gnt_q == PORT_LDR);
                end
            end else begin
                p0_gnt = p0_req;
                p1_gnt = p1_req;
            end
        end
    end

    always_comb begin
        csb0  = 1'b1;
        web0  = 1'b1;
        addr0 = '0;
        din0  = '0;
        if (p0_gnt) begin
            csb0  = 1'b0;
            web0  = ~p0_we;
            addr0 = p0_addr;
            din0  = p0_wdata;
        end else if (p1_gnt) begin
            csb0  = 1'b0;
            web0  = ~p1_we;
            addr0 = p1_addr;
            din0  = p1_wdata;
        end
    end

    always_comb begin
        last_gnt_d = last_gnt_q;
        if (p0_gnt) begin
            last_gnt_d = PORT_MEM;
        end else if (p1_gnt) begin
            last_gnt_d = PORT_LDR;
        end
        rd_pend_d = (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);
        rd_port_d = p1_gnt ? PORT_LDR : PORT_MEM;
    end

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            last_gnt_q <= PORT_LDR;
            rd_pend_q  <= 1'b0;
            rd_port_q  <= PORT_MEM;
        end else begin
            last_gnt_q <= last_gnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_port_q  <= rd_port_d;
        end
    end

    assign p0_rvalid = rd_pend_q & (rd_port_q == PORT_MEM);
    assign p1_rvalid = rd_pend_q & (rd_port_q == PORT_LDR);
    assign p0_rdata  = dout0;
    assign p1_rdata  = dout0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench: instance a is fixed-priority (STARVE_MAX=8), instance b is
// round-robin. Both share stimulus and each has its own SRAM model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_dmem_port_arbiter;

    localparam int unsigned AW = 9;
    localparam int unsigned DW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 1'b0, p1_we = 1'b0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;

    logic          a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid, a_csb0, a_web0;
    logic [DW-1:0] a_p0_rdata, a_p1_rdata, a_din0, a_dout0;
    logic [AW-1:0] a_addr0;
    logic          b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid, b_csb0, b_web0;
    logic [DW-1:0] b_p0_rdata, b_p1_rdata, b_din0, b_dout0;
    logic [AW-1:0] b_addr0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(
        .ADDR_W (AW), .DATA_W (DW), .FIXED_PRIO (1'b1), .STARVE_MAX (8)
    ) dut_a (
        .CLK (clk), .RSTn (rstn), .EN (en),
        .p0_req (p0_req), .p0_we (p0_we), .p0_addr (p0_addr), .p0_wdata (p0_wdata),
        .p1_req (p1_req), .p1_we (p1_we), .p1_addr (p1_addr), .p1_wdata (p1_wdata),
        .p0_gnt (a_p0_gnt), .p1_gnt (a_p1_gnt),
        .p0_rvalid (a_p0_rvalid), .p1_rvalid (a_p1_rvalid),
        .p0_rdata (a_p0_rdata), .p1_rdata (a_p1_rdata),
        .csb0 (a_csb0), .web0 (a_web0), .addr0 (a_addr0), .din0 (a_din0),
        .dout0 (a_dout0)
    );

    dmem_port_arbiter #(
        .ADDR_W (AW), .DATA_W (DW), .FIXED_PRIO (1'b0), .STARVE_MAX (8)
    ) dut_b (
        .CLK (clk), .RSTn (rstn), .EN (en),
        .p0_req (p0_req), .p0_we (p0_we), .p0_addr (p0_addr), .p0_wdata (p0_wdata),
        .p1_req (p1_req), .p1_we (p1_we), .p1_addr (p1_addr), .p1_wdata (p1_wdata),
        .p0_gnt (b_p0_gnt), .p1_gnt (b_p1_gnt),
        .p0_rvalid (b_p0_rvalid), .p1_rvalid (b_p1_rvalid),
        .p0_rdata (b_p0_rdata), .p1_rdata (b_p1_rdata),
        .csb0 (b_csb0), .web0 (b_web0), .addr0 (b_addr0), .din0 (b_din0),
        .dout0 (b_dout0)
    );

    // SRAM models: 1-cycle read latency, write on the access edge.
    logic [DW-1:0] mem_a [512];
    logic [DW-1:0] mem_b [512];

    always @(posedge clk) begin
        if (!a_csb0) begin
            if (!a_web0) mem_a[a_addr0] <= a_din0;
            else         a_dout0 <= mem_a[a_addr0];
        end
        if (!b_csb0) begin
            if (!b_web0) mem_b[b_addr0] <= b_din0;
            else         b_dout0 <= mem_b[b_addr0];
        end
    end

    task automatic idle_inputs();
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        en = 1'b1;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({a_csb0, a_web0} !== 2'b11 || {b_csb0, b_web0} !== 2'b11) begin
            errors++;
            $display("FAIL reset_pins csb/web a=%b%b b=%b%b want 11",
                     a_csb0, a_web0, b_csb0, b_web0);
        end
        checks++;
        if (a_addr0 !== '0 || a_din0 !== '0 || b_addr0 !== '0 || b_din0 !== '0) begin
            errors++;
            $display("FAIL reset_bus addr0 a=%h b=%h din0 a=%h b=%h want 0",
                     a_addr0, b_addr0, a_din0, b_din0);
        end
        checks++;
        if ({a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid,
             b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid} !== 8'h00) begin
            errors++;
            $display("FAIL reset_handshake gnt/rvalid a=%b%b%b%b b=%b%b%b%b want 0",
                     a_p0_gnt, a_p1_gnt, a_p0_rvalid, a_p1_rvalid,
                     b_p0_gnt, b_p1_gnt, b_p0_rvalid, b_p1_rvalid);
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h038; p0_wdata = 32'h0000_0002;
        #1;
        checks++;
        if (a_p0_gnt !== 1'b1 || a_p1_gnt !== 1'b0 || a_csb0 !== 1'b0 || a_web0 !== 1'b0 ||
            a_addr0 !== 9'h038 || a_din0 !== 32'h2) begin
            errors++;
            $display("FAIL wr_pins gnt=%b%b csb=%b web=%b addr=%h din=%h want 10 0 0 038 2",
                     a_p0_gnt, a_p1_gnt, a_csb0, a_web0, a_addr0, a_din0);
        end
        @(negedge clk);
        idle_inputs();
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h038;
        #1;
        checks++;
        if (a_p1_gnt !== 1'b1 || a_web0 !== 1'b1 || a_csb0 !== 1'b0 || a_addr0 !== 9'h038) begin
            errors++;
            $display("FAIL rd_grant p1_gnt=%b csb=%b web=%b addr=%h want 1 0 1 038",
                     a_p1_gnt, a_csb0, a_web0, a_addr0);
        end
        checks++;
        if (a_p0_rvalid !== 1'b0 || a_p1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL wr_no_resp rvalid=%b%b want 00", a_p0_rvalid, a_p1_rvalid);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (a_p1_rvalid !== 1'b1 || a_p1_rdata !== 32'h2 || a_p0_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_return p1_rvalid=%b p1_rdata=%h p0_rvalid=%b want 1 2 0",
                     a_p1_rvalid, a_p1_rdata, a_p0_rvalid);
        end
        checks++;
        if (a_csb0 !== 1'b1) begin
            errors++;
            $display("FAIL rd_idle csb0=%b want 1", a_csb0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_p1_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rd_single p1_rvalid=%b want 0", a_p1_rvalid);
        end
    endtask

    task automatic test_starvation();
        int bad = 0;
        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h100; p0_wdata = i;
            p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h101; p1_wdata = i;
            #1;
            checks++;
            if (a_p1_gnt !== ((i % 9) == 8) || a_p0_gnt !== ((i % 9) != 8)) begin
                errors++;
                bad++;
                if (bad < 6)
                    $display("FAIL starve_cycle %0d gnt p0/p1=%b%b want %b%b", i,
                             a_p0_gnt, a_p1_gnt, (i % 9) != 8, (i % 9) == 8);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_en_drop();
        @(negedge clk);
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 9'h038;
        #1;
        checks++;
        if (a_p0_gnt !== 1'b1 || a_web0 !== 1'b1 || b_p0_gnt !== 1'b1) begin
            errors++;
            $display("FAIL en_rd_grant a_gnt=%b web=%b b_gnt=%b want 1 1 1",
                     a_p0_gnt, a_web0, b_p0_gnt);
        end
        @(negedge clk);
        en = 1'b0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h038;
        #1;
        checks++;
        if (a_p0_rvalid !== 1'b1 || a_p0_rdata !== 32'h2 || b_p0_rvalid !== 1'b1) begin
            errors++;
            $display("FAIL en_rvalid a=%b rdata=%h b=%b want 1 2 1",
                     a_p0_rvalid, a_p0_rdata, b_p0_rvalid);
        end
        checks++;
        if ({a_p0_gnt, a_p1_gnt, b_p0_gnt, b_p1_gnt} !== 4'b0000 ||
            a_csb0 !== 1'b1 || b_csb0 !== 1'b1) begin
            errors++;
            $display("FAIL en_block gnt=%b%b%b%b csb a=%b b=%b want 0000 1 1",
                     a_p0_gnt, a_p1_gnt, b_p0_gnt, b_p1_gnt, a_csb0, b_csb0);
        end
        @(negedge clk);
        #1;
        checks++;
        if (a_p0_rvalid !== 1'b0 || a_csb0 !== 1'b1 || a_p0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL en_hold rvalid=%b csb=%b gnt=%b want 0 1 0",
                     a_p0_rvalid, a_csb0, a_p0_gnt);
        end
        @(negedge clk);
        idle_inputs();
        en = 1'b1;
    endtask

    task automatic test_round_robin();
        int bad = 0;
        rstn = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h110;
            p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h111;
            #1;
            checks++;
            if (b_p0_gnt !== ((i % 2) == 0) || b_p1_gnt !== ((i % 2) == 1)) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL rr_cycle %0d gnt p0/p1=%b%b want %b%b", i,
                             b_p0_gnt, b_p1_gnt, (i % 2) == 0, (i % 2) == 1);
            end
        end
        // Last grant went to port 1; a lone port 1 request is still granted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            p0_req = 1'b0;
            #1;
            checks++;
            if (b_p1_gnt !== 1'b1 || b_p0_gnt !== 1'b0) begin
                errors++;
                $display("FAIL rr_single %0d gnt p0/p1=%b%b want 01", i, b_p0_gnt, b_p1_gnt);
            end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid_read();
        int bad = 0;
        @(negedge clk);
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 9'h038;
        #1;
        checks++;
        if (a_p1_gnt !== 1'b1 || b_p1_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_rd_grant a=%b b=%b want 1 1", a_p1_gnt, b_p1_gnt);
        end
        rstn = 1'b0;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid} !== 4'b0000) begin
                errors++;
                $display("FAIL rst_rd_drop %0d rvalid a=%b%b b=%b%b want 0",
                         i, a_p0_rvalid, a_p1_rvalid, b_p0_rvalid, b_p1_rvalid);
            end
            @(negedge clk);
        end
        // Build up a nonzero wait count and a port-0 last grant, then reset.
        for (int i = 0; i < 5; i++) begin
            p0_req = 1'b1; p0_we = 1'b1; p0_addr = 9'h120;
            p1_req = 1'b1; p1_we = 1'b1; p1_addr = 9'h121;
            @(negedge clk);
        end
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (a_p1_gnt !== (i == 8)) begin
                errors++;
                bad++;
                if (bad < 4)
                    $display("FAIL rst_starve_cnt cycle %0d p1_gnt=%b want %b",
                             i, a_p1_gnt, i == 8);
            end
            if (i == 0) begin
                checks++;
                if (b_p0_gnt !== 1'b1 || b_p1_gnt !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_last_gnt rr first gnt p0/p1=%b%b want 10",
                             b_p0_gnt, b_p1_gnt);
                end
            end
            @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_starvation();
        test_en_drop();
        test_round_robin();
        test_reset_mid_read();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
